bk_kbd_ctl: RTL and testbench
=============================

Name: bk_kbd_ctl

Overview:
Keyboard front-end feeding the BK core's keyboard registers (177660/177662) and the STOP/keydown status bits.
- Consumes PS/2 scan-code bytes (set 2) from an external deserializer.
- Tracks make/break and E0 prefixes and the modifier state.
- Translates keys to BK 7-bit codes and queues them in a small FIFO.
- Presents the FIFO head as kbd_data/kbd_ar2/kbd_available until the core reads it.

Parameters:
FIFO_AW, 2, log2 of key FIFO depth (depth 4).
KEYDOWN_MAX, 7, saturation value of the held-key counter.

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
ce  in  1  core clock enable; read_kbd is sampled only when ce=1
sc_valid  in  1  one-clk strobe: sc_byte valid
sc_byte  in  8  PS/2 scan-code byte
read_kbd  in  1  core is accessing the key data register
kbd_available  out  1  FIFO non-empty
kbd_data  out  8  FIFO head code; bit7 always 0
kbd_ar2  out  1  FIFO head AR2 flag
stopkey  out  1  STOP (Esc) currently held
keydown  out  1  at least one mapped non-modifier key held
overflow  out  1  sticky: key dropped because FIFO was full

Behaviour:
Decoder flags (cleared on any non-prefix byte after use):
- E0 sets ext; F0 sets brk.
- Next non-prefix byte is the key event: make if brk=0, break if brk=1.
- E1 and FA/AA/EE/FE bytes are discarded and clear both flags.

Modifiers (make sets, break clears; never enqueued):
- Shift: 12, 59.
- Ctrl: 14 / E0 14.
- Alt = AR2: 11 / E0 11.

Translation (make events only; unlisted codes ignored):
- Letters A–Z: 0x41–0x5A with shift; 0x61–0x7A without.
- Digits 0–9: 0x30–0x39.
- Enter 5A: 012. Space 29: 040. Backspace 66: 030. Tab 0D: 011.
- E0 6B left: 010. E0 74 right: 031. E0 75 up: 032. E0 72 down: 033.
- Ctrl held and code in 0x40–0x7F: code & 037.
- Esc 76 is not enqueued. Its make sets stopkey; its break clears it.

Enqueue:
- Entry {ar2, code[6:0]} is written on the clk after the event byte's sc_valid.
- Latency is 2 clk from sc_valid of the final byte to kbd_available=1 when the FIFO was empty.
- If the FIFO is full, the entry is dropped and overflow is set. Overflow clears only on reset.
- Typematic repeat makes are enqueued as new keys.

Dequeue:
- On a clk with ce=1 and read_kbd=1 and FIFO non-empty, pop once.
- read_kbd held high across several ce cycles pops only once: pop on the rising edge of the ce-sampled read_kbd.
- Outputs are driven from the head register with no combinational path from read_kbd.
- Enqueue and pop in the same clk: both take effect and the count is unchanged. On a full FIFO a simultaneous pop frees the slot, so no drop occurs.
- Pointers wrap modulo depth.

keydown counter:
- Increments on make of a mapped key or Esc and saturates at KEYDOWN_MAX.
- Decrements on break of a mapped key or Esc and never goes below 0.
- Typematic repeat makes do not increment: a per-key held bit is not required; instead, makes of the same code as the last make while counter>0 are ignored.
- keydown = (counter != 0).

Reset (async, reset_n=0):
- FIFO empty, pointers 0.
- kbd_available=0, kbd_data=0, kbd_ar2=0, stopkey=0, keydown=0, overflow=0.
- All modifiers and decoder flags cleared.
- Reset mid-sequence (e.g. after F0) discards the partial event.

Test Plan:
- Reset, send 1C (A), no shift → kbd_available=1 within 2 clk, kbd_data=0x61, kbd_ar2=0; pulse read_kbd with ce → available=0.
- Send 12, 1C, F0 1C, F0 12 → one entry, data=0x41; keydown goes 1 then 0; no entries for modifiers.
- Send 11 (Alt), 16 (1) → data=0x31, kbd_ar2=1; send 14, 21 (C) → data=003.
- Send E0 75 → data=032. Send E0 F0 75 → no entry, keydown=0.
- Enqueue 5 distinct keys without reading → 4 queued, overflow=1. Read 4 times, holding read_kbd for 3 ce each read → codes in order, exactly one pop per read, empty afterwards.
- Send 76 → stopkey=1, no entry. Assert reset_n=0 after F0 only → all outputs 0. Send 76 again → stopkey=1.

Source files
------------

// File: rtl/bk_kbd_ctl_if.sv
// Keyboard front-end bus: scan-code input, core read strobe and the key/status
// outputs that feed the BK keyboard registers.
interface bk_kbd_ctl_if;
    logic       ce;
    logic       sc_valid;
    logic [7:0] sc_byte;
    logic       read_kbd;
    logic       kbd_available;
    logic [7:0] kbd_data;
    logic       kbd_ar2;
    logic       stopkey;
    logic       keydown;
    logic       overflow;

    modport master (
        output ce, sc_valid, sc_byte, read_kbd,
        input  kbd_available, kbd_data, kbd_ar2, stopkey, keydown, overflow
    );

    modport slave (
        input  ce, sc_valid, sc_byte, read_kbd,
        output kbd_available, kbd_data, kbd_ar2, stopkey, keydown, overflow
    );
endinterface

// File: rtl/bk_kbd_ctl.sv
// PS/2 set-2 scan-code decoder, BK key translation and key FIFO feeding the
// BK keyboard registers plus the STOP/keydown status bits.
module bk_kbd_ctl #(
    parameter int FIFO_AW     = 2,
    parameter int KEYDOWN_MAX = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    bk_kbd_ctl_if.slave kbd
);
    localparam int                DEPTH    = 1 << FIFO_AW;
    localparam int                CW       = $clog2(KEYDOWN_MAX + 1);
    localparam logic [FIFO_AW:0]  FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [CW-1:0]     KD_MAX   = CW'(KEYDOWN_MAX);

    logic               ext_q, ext_d, brk_q, brk_d;
    logic               shift_q, shift_d, ctrl_q, ctrl_d, alt_q, alt_d;
    logic               stop_q, stop_d;
    logic [CW-1:0]      kd_cnt_q, kd_cnt_d;
    logic [8:0]         last_q, last_d;
    logic               ev_valid_q, ev_valid_d;
    logic [7:0]         ev_entry_q, ev_entry_d;
    logic               rd_lvl_q, rd_lvl_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [7:0]         mem_q [DEPTH];
    logic [7:0]         mem_d [DEPTH];

    logic       hit, is_event, is_make, is_esc, push, pop, avail;
    logic [6:0] code, code_out;
    logic [7:0] b;
    logic [8:0] key_id;

    assign b      = kbd.sc_byte;
    assign key_id = {ext_q, b};

    // NOTE: every variable written in an always_comb gets a default first, or a latch is inferred.
    always_comb begin
        hit  = 1'b1;
        code = 7'h00;
        case (key_id)
            9'h01C: code = 7'h41; 9'h032: code = 7'h42; 9'h021: code = 7'h43; 9'h023: code = 7'h44;
            9'h024: code = 7'h45; 9'h02B: code = 7'h46; 9'h034: code = 7'h47; 9'h033: code = 7'h48;
            9'h043: code = 7'h49; 9'h03B: code = 7'h4A; 9'h042: code = 7'h4B; 9'h04B: code = 7'h4C;
            9'h03A: code = 7'h4D; 9'h031: code = 7'h4E; 9'h044: code = 7'h4F; 9'h04D: code = 7'h50;
            9'h015: code = 7'h51; 9'h02D: code = 7'h52; 9'h01B: code = 7'h53; 9'h02C: code = 7'h54;
            9'h03C: code = 7'h55; 9'h02A: code = 7'h56; 9'h01D: code = 7'h57; 9'h022: code = 7'h58;
            9'h035: code = 7'h59; 9'h01A: code = 7'h5A;
            9'h045: code = 7'h30; 9'h016: code = 7'h31; 9'h01E: code = 7'h32; 9'h026: code = 7'h33;
            9'h025: code = 7'h34; 9'h02E: code = 7'h35; 9'h036: code = 7'h36; 9'h03D: code = 7'h37;
            9'h03E: code = 7'h38; 9'h046: code = 7'h39;
            9'h05A: code = 7'h0A; 9'h029: code = 7'h20; 9'h066: code = 7'h18; 9'h00D: code = 7'h09;
            9'h16B: code = 7'h08; 9'h174: code = 7'h19; 9'h175: code = 7'h1A; 9'h172: code = 7'h1B;
            default: hit = 1'b0;
        endcase
        code_out = code;
        if (code >= 7'h41 && code <= 7'h5A && !shift_q) code_out = code | 7'h20;
        // Ctrl folds anything in the 0x40-0x7F column down to a control code.
        if (ctrl_q && code_out[6]) code_out = {2'b00, code_out[4:0]};
    end

    always_comb begin
        is_event   = kbd.sc_valid && !(b inside {8'hE0, 8'hF0, 8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE});
        is_make    = !brk_q;
        is_esc     = !ext_q && (b == 8'h76);
        ext_d      = ext_q;
        brk_d      = brk_q;
        shift_d    = shift_q;
        ctrl_d     = ctrl_q;
        alt_d      = alt_q;
        stop_d     = stop_q;
        kd_cnt_d   = kd_cnt_q;
        last_d     = last_q;
        ev_valid_d = 1'b0;
        ev_entry_d = ev_entry_q;
        if (kbd.sc_valid) begin
            if (b == 8'hE0)      ext_d = 1'b1;
            else if (b == 8'hF0) brk_d = 1'b1;
            else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
        if (is_event) begin
            if (!ext_q && (b == 8'h12 || b == 8'h59)) shift_d = is_make;
            else if (b == 8'h14)                      ctrl_d  = is_make;
            else if (b == 8'h11)                      alt_d   = is_make;
            else if (hit || is_esc) begin
                if (is_esc) stop_d = is_make;
                if (is_make) begin
                    // A repeat of the last make while keys are held is typematic, not a new key.
                    if (!(kd_cnt_q != '0 && last_q == key_id) && kd_cnt_q != KD_MAX)
                        kd_cnt_d = kd_cnt_q + 1'b1;
                    last_d     = key_id;
                    ev_valid_d = hit;
                    ev_entry_d = {alt_q, code_out};
                end else if (kd_cnt_q != '0) begin
                    kd_cnt_d = kd_cnt_q - 1'b1;
                end
            end
        end
    end

    always_comb begin
        pop      = kbd.ce && kbd.read_kbd && !rd_lvl_q && (count_q != '0);
        rd_lvl_d = kbd.ce ? kbd.read_kbd : rd_lvl_q;
        push     = ev_valid_q && ((count_q != FULL_CNT) || pop);
        ovf_d    = ovf_q | (ev_valid_q && !push);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = ev_entry_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            shift_q    <= 1'b0;
            ctrl_q     <= 1'b0;
            alt_q      <= 1'b0;
            stop_q     <= 1'b0;
            kd_cnt_q   <= '0;
            last_q     <= '0;
            ev_valid_q <= 1'b0;
            ev_entry_q <= '0;
            rd_lvl_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            shift_q    <= shift_d;
            ctrl_q     <= ctrl_d;
            alt_q      <= alt_d;
            stop_q     <= stop_d;
            kd_cnt_q   <= kd_cnt_d;
            last_q     <= last_d;
            ev_valid_q <= ev_valid_d;
            ev_entry_q <= ev_entry_d;
            rd_lvl_q   <= rd_lvl_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    // NOTE: FIFO storage is not reset; the head is masked to zero whenever the count is zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign avail             = (count_q != '0);
    assign kbd.kbd_available = avail;
    assign kbd.kbd_data      = avail ? {1'b0, mem_q[rd_ptr_q][6:0]} : 8'h00;
    assign kbd.kbd_ar2       = avail & mem_q[rd_ptr_q][7];
    assign kbd.stopkey       = stop_q;
    assign kbd.keydown       = (kd_cnt_q != '0);
    assign kbd.overflow      = ovf_q;
endmodule

// File: tb/tb_bk_kbd_ctl.sv
// Self-checking bench for bk_kbd_ctl: vector table, corner-case sequences and
// randomized key traffic against a byte-level reference model.
module tb_bk_kbd_ctl;
    localparam int OPB = 0;
    localparam int OPR = 1;

    typedef struct {
        int         op;
        logic [7:0] b;
        logic       av;
        logic [7:0] data;
        logic       ar2;
        logic       stop;
        logic       kd;
        logic       ov;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    bk_kbd_ctl_if kif ();

    bk_kbd_ctl #(.FIFO_AW(2), .KEYDOWN_MAX(7)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .kbd     (kif.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model state
    bit         m_ext, m_brk, m_shift, m_ctrl, m_alt, m_stop, m_ovf;
    int         m_cnt, m_last;
    logic [7:0] m_q[$];

    logic [8:0] rkeys [24] = '{9'h01C, 9'h032, 9'h021, 9'h04D, 9'h01A, 9'h045, 9'h016, 9'h046,
                               9'h05A, 9'h029, 9'h066, 9'h00D, 9'h16B, 9'h174, 9'h175, 9'h172,
                               9'h012, 9'h059, 9'h014, 9'h114, 9'h011, 9'h111, 9'h076, 9'h005};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic av, input logic [7:0] data,
                             input logic ar2, input logic stop, input logic kd, input logic ov);
        check({name, ".avail"},    8'(kif.kbd_available), 8'(av));
        check({name, ".data"},     kif.kbd_data,          data);
        check({name, ".ar2"},      8'(kif.kbd_ar2),       8'(ar2));
        check({name, ".stopkey"},  8'(kif.stopkey),       8'(stop));
        check({name, ".keydown"},  8'(kif.keydown),       8'(kd));
        check({name, ".overflow"}, 8'(kif.overflow),      8'(ov));
    endtask

    function automatic vec_t mkv(int op, logic [7:0] b, logic av, logic [7:0] data,
                                 logic ar2, logic stop, logic kd, logic ov);
        vec_t v;
        v.op = op; v.b = b; v.av = av; v.data = data;
        v.ar2 = ar2; v.stop = stop; v.kd = kd; v.ov = ov;
        return v;
    endfunction

    // BK code for a key, or -1 when the key is not translated.
    function automatic int model_code(bit e, logic [7:0] b, bit shift);
        logic [7:0] letters [26];
        logic [7:0] digits [10];
        letters = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        digits  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        if (e) begin
            case (b)
                8'h6B: return 8;
                8'h74: return 'o31;
                8'h75: return 'o32;
                8'h72: return 'o33;
                default: return -1;
            endcase
        end
        for (int i = 0; i < 26; i++) if (letters[i] == b) return (shift ? 'h41 : 'h61) + i;
        for (int i = 0; i < 10; i++) if (digits[i] == b) return 'h30 + i;
        case (b)
            8'h5A: return 'o12;
            8'h29: return 'o40;
            8'h66: return 'o30;
            8'h0D: return 'o11;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_shift = 0; m_ctrl = 0; m_alt = 0; m_stop = 0; m_ovf = 0;
        m_cnt = 0; m_last = -1;
        m_q.delete();
    endtask

    task automatic model_held(bit mk, int id);
        if (mk) begin
            if (!(m_cnt > 0 && m_last == id)) m_cnt = (m_cnt < 7) ? m_cnt + 1 : 7;
            m_last = id;
        end else if (m_cnt > 0) begin
            m_cnt--;
        end
    endtask

    task automatic model_byte(logic [7:0] b);
        bit e, mk;
        int c;
        if (b == 8'hE0) begin m_ext = 1; return; end
        if (b == 8'hF0) begin m_brk = 1; return; end
        e = m_ext; mk = !m_brk;
        m_ext = 0; m_brk = 0;
        if (b inside {8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE}) return;
        if (!e && (b == 8'h12 || b == 8'h59)) m_shift = mk;
        else if (b == 8'h14) m_ctrl = mk;
        else if (b == 8'h11) m_alt = mk;
        else if (!e && b == 8'h76) begin
            m_stop = mk;
            model_held(mk, int'(b));
        end else begin
            c = model_code(e, b, m_shift);
            if (c >= 0) begin
                model_held(mk, (e ? 256 : 0) + int'(b));
                if (mk) begin
                    if (m_ctrl && c >= 'h40 && c <= 'h7F) c = c % 32;
                    if (m_q.size() < 4) m_q.push_back({m_alt, 7'(c)});
                    else m_ovf = 1;
                end
            end
        end
    endtask

    task automatic check_model(input string name);
        logic av;
        av = (m_q.size() != 0);
        check_all(name, av, av ? {1'b0, m_q[0][6:0]} : 8'h00, av ? m_q[0][7] : 1'b0,
                  m_stop, m_cnt != 0, m_ovf);
    endtask

    task automatic send_byte(input logic [7:0] b);
        kif.sc_byte  = b;
        kif.sc_valid = 1'b1;
        @(negedge clk);
        kif.sc_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_read(input int hold_ce);
        kif.read_kbd = 1'b1;
        for (int i = 0; i < hold_ce; i++) begin
            kif.ce = 1'b1;
            @(negedge clk);
            kif.ce = 1'b0;
            @(negedge clk);
        end
        kif.read_kbd = 1'b0;
        kif.ce = 1'b1;
        @(negedge clk);
        kif.ce = 1'b0;
    endtask

    task automatic apply_reset();
        kif.sc_valid = 1'b0;
        kif.ce       = 1'b0;
        kif.read_kbd = 1'b0;
        reset_n      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_model(input logic [7:0] b, input string name);
        send_byte(b);
        model_byte(b);
        check_model(name);
    endtask

    vec_t tbl[$];

    initial begin
        logic [7:0] exp_codes [5];
        logic [8:0] k;
        exp_codes = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        kif.sc_byte = 8'h00;
        apply_reset();
        check_all("reset", 0, 8'h00, 0, 0, 0, 0);

        // ---------------- vector table ----------------
        tbl.push_back(mkv(OPB, 8'h1C, 1, 8'h61, 0, 0, 1, 0));
        tbl.push_back(mkv(OPB, 8'hF0, 1, 8'h61, 0, 0, 1, 0));
        tbl.push_back(mkv(OPB, 8'h1C, 1, 8'h61, 0, 0, 0, 0));
        tbl.push_back(mkv(OPR, 8'h00, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mkv(OPB, 8'h12, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mkv(OPB, 8'h1C, 1, 8'h41, 0, 0, 1, 0));
        tbl.push_back(mkv(OPB, 8'hF0, 1, 8'h41, 0, 0, 1, 0));
        tbl.push_back(mkv(OPB, 8'h1C, 1, 8'h41, 0, 0, 0, 0));
        tbl.push_back(mkv(OPB, 8'hF0, 1, 8'h41, 0, 0, 0, 0));
        tbl.push_back(mkv(OPB, 8'h12, 1, 8'h41, 0, 0, 0, 0));
        tbl.push_back(mkv(OPR, 8'h00, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mkv(OPB, 8'h11, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mkv(OPB, 8'h16, 1, 8'h31, 1, 0, 1, 0));
        tbl.push_back(mkv(OPR, 8'h00, 0, 8'h00, 0, 0, 1, 0));
        tbl.push_back(mkv(OPB, 8'hF0, 0, 8'h00, 0, 0, 1, 0));
        tbl.push_back(mkv(OPB, 8'h16, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mkv(OPB, 8'hF0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mkv(OPB, 8'h11, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mkv(OPB, 8'h14, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mkv(OPB, 8'h21, 1, 8'h03, 0, 0, 1, 0));
        tbl.push_back(mkv(OPB, 8'hF0, 1, 8'h03, 0, 0, 1, 0));
        tbl.push_back(mkv(OPB, 8'h21, 1, 8'h03, 0, 0, 0, 0));
        tbl.push_back(mkv(OPB, 8'hF0, 1, 8'h03, 0, 0, 0, 0));
        tbl.push_back(mkv(OPB, 8'h14, 1, 8'h03, 0, 0, 0, 0));
        tbl.push_back(mkv(OPR, 8'h00, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mkv(OPB, 8'hE0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mkv(OPB, 8'h75, 1, 8'h1A, 0, 0, 1, 0));
        tbl.push_back(mkv(OPR, 8'h00, 0, 8'h00, 0, 0, 1, 0));
        tbl.push_back(mkv(OPB, 8'hE0, 0, 8'h00, 0, 0, 1, 0));
        tbl.push_back(mkv(OPB, 8'hF0, 0, 8'h00, 0, 0, 1, 0));
        tbl.push_back(mkv(OPB, 8'h75, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mkv(OPB, 8'h05, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mkv(OPB, 8'h5A, 1, 8'h0A, 0, 0, 1, 0));
        tbl.push_back(mkv(OPB, 8'hF0, 1, 8'h0A, 0, 0, 1, 0));
        tbl.push_back(mkv(OPB, 8'h5A, 1, 8'h0A, 0, 0, 0, 0));
        tbl.push_back(mkv(OPR, 8'h00, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mkv(OPB, 8'h76, 0, 8'h00, 0, 1, 1, 0));
        tbl.push_back(mkv(OPB, 8'hF0, 0, 8'h00, 0, 1, 1, 0));
        tbl.push_back(mkv(OPB, 8'h76, 0, 8'h00, 0, 0, 0, 0));
        foreach (tbl[i]) begin
            if (tbl[i].op == OPR) do_read(2);
            else send_byte(tbl[i].b);
            check_all($sformatf("tbl%0d", i), tbl[i].av, tbl[i].data, tbl[i].ar2,
                      tbl[i].stop, tbl[i].kd, tbl[i].ov);
        end

        // ---------------- two-clock enqueue latency ----------------
        apply_reset();
        kif.sc_byte  = 8'h1C;
        kif.sc_valid = 1'b1;
        @(posedge clk); #1;
        kif.sc_valid = 1'b0;
        check("lat_edge1.avail", 8'(kif.kbd_available), 8'h00);
        @(posedge clk); #1;
        check("lat_edge2.avail", 8'(kif.kbd_available), 8'h01);
        check("lat_edge2.data", kif.kbd_data, 8'h61);
        @(negedge clk);

        // ---------------- typematic repeats ----------------
        apply_reset();
        send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
        check_all("typ_held", 1, 8'h61, 0, 0, 1, 0);
        send_byte(8'hF0); send_byte(8'h1C);
        check_all("typ_break", 1, 8'h61, 0, 0, 0, 0);
        do_read(1); do_read(1);
        check_all("typ_two_read", 1, 8'h61, 0, 0, 0, 0);
        do_read(1);
        check_all("typ_empty", 0, 8'h00, 0, 0, 0, 0);

        // ---------------- overflow, held reads ----------------
        apply_reset();
        foreach (exp_codes[i]) begin
            k = rkeys[i == 3 ? 4 : i];
        end
        send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
        send_byte(8'h32); send_byte(8'hF0); send_byte(8'h32);
        send_byte(8'h21); send_byte(8'hF0); send_byte(8'h21);
        send_byte(8'h23); send_byte(8'hF0); send_byte(8'h23);
        check_all("ovf_full", 1, 8'h61, 0, 0, 0, 0);
        send_byte(8'h24); send_byte(8'hF0); send_byte(8'h24);
        check_all("ovf_drop", 1, 8'h61, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            do_read(3);
            if (i < 3) check_all($sformatf("ovf_read%0d", i), 1, exp_codes[i + 1], 0, 0, 0, 1);
            else check_all("ovf_empty", 0, 8'h00, 0, 0, 0, 1);
        end

        // ---------------- enqueue and pop together on a full FIFO ----------------
        apply_reset();
        send_byte(8'h1C); send_byte(8'h32); send_byte(8'h21); send_byte(8'h23);
        kif.sc_byte  = 8'h24;
        kif.sc_valid = 1'b1;
        @(negedge clk);
        kif.sc_valid = 1'b0;
        kif.ce       = 1'b1;
        kif.read_kbd = 1'b1;
        @(negedge clk);
        kif.read_kbd = 1'b0;
        @(negedge clk);
        kif.ce = 1'b0;
        check_all("simul", 1, 8'h62, 0, 0, 1, 0);
        for (int i = 2; i < 5; i++) begin
            do_read(1);
            check($sformatf("simul_read%0d", i), kif.kbd_data, exp_codes[i]);
        end
        do_read(1);
        check_all("simul_empty", 0, 8'h00, 0, 0, 1, 0);

        // ---------------- keydown saturation ----------------
        apply_reset();
        foreach (rkeys[i]) if (i < 8) send_byte(rkeys[i][7:0]);
        for (int i = 0; i < 7; i++) begin
            if (i == 6) check("sat_before_last.keydown", 8'(kif.keydown), 8'h01);
            send_byte(8'hF0);
            send_byte(rkeys[i][7:0]);
        end
        check("sat_after.keydown", 8'(kif.keydown), 8'h00);

        // ---------------- reset after a lone F0 ----------------
        apply_reset();
        send_byte(8'h1C);
        send_byte(8'h76);
        send_byte(8'hF0);
        reset_n = 1'b0;
        #1;
        check_all("rst_mid", 0, 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_byte(8'h76);
        check_all("rst_esc", 0, 8'h00, 0, 1, 1, 0);

        // ---------------- randomized traffic vs. model ----------------
        apply_reset();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 22) begin
                do_read($urandom_range(1, 3));
                if (m_q.size() != 0) void'(m_q.pop_front());
                check_model($sformatf("rnd%0d.read", n));
            end else begin
                k = rkeys[$urandom_range(0, 23)];
                if ($urandom_range(0, 9) == 0) begin
                    send_model(8'hE0, $sformatf("rnd%0d.pre", n));
                    send_model(8'hFA, $sformatf("rnd%0d.junk", n));
                end
                if (k[8]) send_model(8'hE0, $sformatf("rnd%0d.e0", n));
                if ($urandom_range(0, 99) < 40) send_model(8'hF0, $sformatf("rnd%0d.f0", n));
                send_model(k[7:0], $sformatf("rnd%0d.key", n));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
